tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Shared-prescaler tick scheduler. Divides the system clock by a fixed base ratio and fans the base tick out to four independently programmable channels. Each channel emits a one-cycle enable pulse and a 50%-duty toggle waveform. It sits between the board clock and slow consumers such as LED blinkers, display scanners and debouncers, and is configured over a valid/ready write port while stopped.

## Interface
Parameters:
- BASE_DIV, default 25000000: clk cycles per base tick; legal range ≥ 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  level-sampled run request
- stop  in  1  level-sampled halt request; wins over start
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_ch  in  2  target channel 0..3
- cfg_period  in  8  channel period in base ticks; 0 = channel disabled
- running  out  1  high in RUN state
- base_tick  out  1  one-cycle pulse per base period (RUN only)
- tick  out  4  per-channel one-cycle enable pulse, registered
- wave  out  4  per-channel toggle output, registered

## Operation
- States: IDLE, RUN.
- Reset state: IDLE. Reset values: running=0, base_tick=0, tick=0, wave=0, cfg_ready=1. All period registers, channel counters and the prescaler reset to 0.
- IDLE → RUN: start=1 and stop=0 sampled. RUN → IDLE: stop=1 sampled. start and stop both high: RUN goes to IDLE; IDLE stays IDLE.
- cfg_ready=1 iff state is IDLE.
- On transfer (cfg_valid & cfg_ready), period[cfg_ch] ← cfg_period and cnt[cfg_ch] ← cfg_period. cfg_valid is ignored in RUN; the write is dropped, not queued.
- Config write and start in the same IDLE cycle: the write is accepted and RUN is entered; the new period applies from the first base tick.
- Prescaler, width max(1, clog2(BASE_DIV)):
  - Counts 0..BASE_DIV-1 in RUN and wraps to 0.
  - base_tick = RUN & (count == BASE_DIV-1), combinational decode.
  - With BASE_DIV=1, base_tick is high every RUN cycle.
- Channel i, updated on each base_tick while period[i] ≠ 0:
  - cnt[i]==1: tick[i]←1 next cycle, wave[i] toggles in that same cycle, cnt[i]←period[i].
  - Otherwise: cnt[i] decrements and tick[i]←0.
- period[i]==0: tick[i] and wave[i] stay 0 forever.
- In IDLE:
  - prescaler held at 0
  - every cnt[i] held at period[i]
  - tick=0, wave cleared to 0 on the cycle after entering IDLE
- Period registers survive stop/start; only rst clears them.
- 8-bit period arithmetic never underflows: a 0 period is excluded, and reload happens at 1.

## Timing
- t0 = first cycle with running=1, which is one cycle after start is sampled.
- The k-th base_tick is high at cycle t0 + k·BASE_DIV − 1.
- Channel with period P: tick high at t0 + n·P·BASE_DIV for n=1,2,…, one cycle wide. wave changes on the same cycles.
- Stop sampled at edge e:
  - running=0 from e.
  - Any tick already scheduled for e is suppressed.
  - No further base_tick.
- Restart: timing is relative to the new t0 with full periods. No phase is retained.
- rst mid-operation: all outputs go to reset values immediately (asynchronous). Operation resumes in IDLE at the first edge after deassertion.

## Test plan
BASE_DIV=4 for all scenarios.
- Reset: run with active channels, assert rst mid-count → running=0, tick=0, wave=0, cfg_ready=1 immediately. After release, start with no config → tick stays 0.
- Basic rates: write ch0=1, ch1=3, then start → base_tick at t0+3, t0+7, …; tick[0] at t0+4, t0+8, …; tick[1] at t0+12, t0+24; wave[0] toggles every 4 cycles, wave[1] every 12.
- Config lockout: cfg_valid with ch2=2 during RUN → cfg_ready=0, period unchanged. After stop, the same request is accepted in one cycle.
- Start/stop conflict: start=stop=1 in IDLE → stays IDLE. In RUN → running=0 next edge, tick suppressed even if due that cycle.
- Boundaries: ch3=0 → never ticks. ch2=255 → first tick at t0+1020, second at t0+2040. Config write coincident with start → new period used from the first base tick.
- Restart: stop at t0+6 with ch1=3, then start → ch1 first tick at new t0+12, and wave is 0 at restart.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler producing a base tick, fanned out to four
// programmable channels that each emit a one-cycle tick and a toggle wave.
// Channels are configured over a valid/ready port accepted only while IDLE.

// One channel: period register, down-counter, registered tick/wave outputs.
module tick_channel (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,        // FSM in RUN
    input  logic       halt,       // stop sampled this cycle while in RUN
    input  logic       base_tick,
    input  logic       wr_en,
    input  logic [7:0] wr_period,
    output logic       tick,
    output logic       wave
);
    logic [7:0] period;
    logic [7:0] cnt;

    // Period load and reload while idle; count down on base ticks while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= '0;
            cnt    <= '0;
            tick   <= 1'b0;
            wave   <= 1'b0;
        end else if (!run) begin
            // Idle: outputs cleared, counter parked at a full period so a
            // restart never inherits phase.
            tick <= 1'b0;
            wave <= 1'b0;
            if (wr_en) begin
                period <= wr_period;
                cnt    <= wr_period;
            end else begin
                cnt    <= period;
            end
        end else if (halt) begin
            // Stop edge: any pulse due now is dropped; wave clears next cycle.
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (base_tick && period != 8'd0) begin
                if (cnt == 8'd1) begin
                    tick <= 1'b1;
                    wave <= ~wave;
                    cnt  <= period;
                end else begin
                    cnt  <= cnt - 8'd1;
                end
            end
        end
    end
endmodule

module tick_scheduler #(
    parameter int BASE_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_ch,
    input  logic [7:0] cfg_period,
    output logic       running,
    output logic       base_tick,
    output logic [3:0] tick,
    output logic [3:0] wave
);
    localparam int NUM_LANES = 4;
    localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(BASE_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [PW-1:0] pcnt;
    logic          run;
    logic          halt;

    assign run       = (state == RUN);
    assign halt      = run && stop;
    assign running   = run;
    assign cfg_ready = (state == IDLE);
    assign base_tick = run && (pcnt == PMAX);

    // Run/idle control; stop always wins over start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !stop) state <= RUN;
                RUN:     if (stop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler: free-runs 0..BASE_DIV-1 in RUN, parked at 0 otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (run && !stop) begin
            pcnt <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
        end else begin
            pcnt <= '0;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_ch
            tick_channel u_ch (
                .clk       (clk),
                .rst       (rst),
                .run       (run),
                .halt      (halt),
                .base_tick (base_tick),
                .wr_en     (cfg_valid && cfg_ready && (cfg_ch == 2'(i))),
                .wr_period (cfg_period),
                .tick      (tick[i]),
                .wave      (wave[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with BASE_DIV=4: a cycle-by-cycle vector
// table plus hand-written sequences for restart, long periods and reset.
module tb_tick_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic       running, base_tick;
    logic [3:0] tick, wave;

    int nvec = 0;
    int nmis = 0;

    tick_scheduler #(.BASE_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .running    (running),
        .base_tick  (base_tick),
        .tick       (tick),
        .wave       (wave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s, sp, cv;
        logic [1:0] ch;
        logic [7:0] per;
        logic       r, bt;
        logic [3:0] tk, wv, wm;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic sp, input logic cv,
                       input logic [1:0] ch, input logic [7:0] per,
                       input logic r, input logic bt, input logic [3:0] tk,
                       input logic [3:0] wv, input logic rdy,
                       input logic [3:0] wm = 4'hF);
        vec_t v;
        v.s = s; v.sp = sp; v.cv = cv; v.ch = ch; v.per = per;
        v.r = r; v.bt = bt; v.tk = tk; v.wv = wv; v.rdy = rdy; v.wm = wm;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; cfg_valid = 0; cfg_ch = 0; cfg_period = 0;
    endtask

    initial begin
        int first, second, seen3, tk_or, bt_cnt;
        rst = 1'b1;
        idle_inputs();

        // Table: ch0=1, ch1=3, start/stop conflict, lockout, stop, restart
        add(0,0,1,0,1,   0,0,4'h0,4'h0,1);
        add(0,0,1,1,3,   0,0,4'h0,4'h0,1);
        add(1,1,0,0,0,   0,0,4'h0,4'h0,1);   // start+stop in IDLE
        add(0,0,0,0,0,   0,0,4'h0,4'h0,1);   // still IDLE
        add(1,0,0,0,0,   0,0,4'h0,4'h0,1);
        add(0,0,0,0,0,   1,0,4'h0,4'h0,0);   // t0
        add(0,0,1,2,2,   1,0,4'h0,4'h0,0);   // write in RUN dropped
        add(0,0,0,0,0,   1,0,4'h0,4'h0,0);
        add(0,0,0,0,0,   1,1,4'h0,4'h0,0);   // t0+3
        add(0,0,0,0,0,   1,0,4'h1,4'h1,0);   // t0+4
        add(0,0,0,0,0,   1,0,4'h0,4'h1,0);
        add(0,0,0,0,0,   1,0,4'h0,4'h1,0);
        add(0,0,0,0,0,   1,1,4'h0,4'h1,0);   // t0+7
        add(0,0,0,0,0,   1,0,4'h1,4'h0,0);   // t0+8: ch2 untouched
        add(0,0,0,0,0,   1,0,4'h0,4'h0,0);
        add(0,0,0,0,0,   1,0,4'h0,4'h0,0);
        add(0,0,0,0,0,   1,1,4'h0,4'h0,0);   // t0+11
        add(0,0,0,0,0,   1,0,4'h3,4'h3,0);   // t0+12
        add(0,0,0,0,0,   1,0,4'h0,4'h3,0);
        add(0,0,0,0,0,   1,0,4'h0,4'h3,0);
        add(0,1,0,0,0,   1,1,4'h0,4'h3,0);   // t0+15: stop, ch0 due next
        add(0,0,1,2,2,   0,0,4'h0,4'h0,1,4'h0); // tick suppressed; write ok
        add(0,0,0,0,0,   0,0,4'h0,4'h0,1);
        add(1,0,0,0,0,   0,0,4'h0,4'h0,1);
        add(0,0,0,0,0,   1,0,4'h0,4'h0,0);   // new t0
        add(0,0,0,0,0,   1,0,4'h0,4'h0,0);
        add(0,0,0,0,0,   1,0,4'h0,4'h0,0);
        add(0,0,0,0,0,   1,1,4'h0,4'h0,0);
        add(0,0,0,0,0,   1,0,4'h1,4'h1,0);   // t0+4
        add(0,0,0,0,0,   1,0,4'h0,4'h1,0);
        add(0,0,0,0,0,   1,0,4'h0,4'h1,0);
        add(0,0,0,0,0,   1,1,4'h0,4'h1,0);
        add(0,0,0,0,0,   1,0,4'h5,4'h4,0);   // t0+8: ch0 + ch2
        add(0,0,0,0,0,   1,0,4'h0,4'h4,0);
        add(0,0,0,0,0,   1,0,4'h0,4'h4,0);
        add(0,0,0,0,0,   1,1,4'h0,4'h4,0);
        add(0,0,0,0,0,   1,0,4'h3,4'h7,0);   // t0+12: ch0 + ch1
        add(0,1,0,0,0,   1,0,4'h0,4'h7,0);   // stop
        add(0,0,0,0,0,   0,0,4'h0,4'h0,1,4'h0);
        add(0,0,0,0,0,   0,0,4'h0,4'h0,1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {running, base_tick, tick, wave, cfg_ready}, {1'b0, 1'b0, 4'h0, 4'h0, 1'b1});
        nxt();
        rst = 1'b0;

        foreach (vecs[i]) begin
            start = vecs[i].s; stop = vecs[i].sp; cfg_valid = vecs[i].cv;
            cfg_ch = vecs[i].ch; cfg_period = vecs[i].per;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {running, base_tick, tick, wave & vecs[i].wm, cfg_ready},
                  {vecs[i].r, vecs[i].bt, vecs[i].tk, vecs[i].wv & vecs[i].wm, vecs[i].rdy});
            nxt();
        end
        idle_inputs();

        // Restart: stop at t0+6, restart, ch1 (P=3) first tick at new t0+12
        start = 1; @(negedge clk); nxt(); start = 0;
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) stop = 1;
            @(negedge clk); nxt();
        end
        stop = 0;
        @(negedge clk);
        check("stop_running", {31'd0, running}, 32'd0);
        nxt();
        start = 1; @(negedge clk); nxt(); start = 0;
        @(negedge clk);
        check("restart_wave", {running, wave}, {1'b1, 4'h0});
        first = -1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (tick[1] && first < 0) first = c;
            nxt();
        end
        check("restart_ch1_first", first, 12);
        stop = 1; @(negedge clk); nxt(); stop = 0;
        @(negedge clk); nxt();

        // ch3=0 never ticks; ch2=255 written together with start
        cfg_valid = 1; cfg_ch = 3; cfg_period = 0; @(negedge clk); nxt();
        cfg_ch = 2; cfg_period = 255; start = 1; @(negedge clk); nxt();
        idle_inputs();
        first = -1; second = -1; seen3 = 0;
        for (int c = 0; c < 2100; c++) begin
            if (c > 0) @(negedge clk);
            if (tick[2]) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (tick[3] || wave[3]) seen3 = 1;
            nxt();
        end
        check("ch2_255_first", first, 1020);
        check("ch2_255_second", second, 2040);
        check("ch3_zero_quiet", seen3, 0);
        stop = 1; @(negedge clk); nxt(); stop = 0;
        @(negedge clk); nxt();

        // Asynchronous reset mid-run, then start with no config
        start = 1; @(negedge clk); nxt(); start = 0;
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 13) nxt();
        end
        check("pre_reset_wave0", {31'd0, wave[0]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {running, base_tick, tick, wave, cfg_ready}, {1'b0, 1'b0, 4'h0, 4'h0, 1'b1});
        @(posedge clk); #1 rst = 1'b0;
        start = 1; @(negedge clk); nxt(); start = 0;
        tk_or = 0; bt_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (tick != 4'h0 || wave != 4'h0) tk_or = 1;
            if (base_tick) bt_cnt++;
            nxt();
        end
        check("post_reset_no_tick", tk_or, 0);
        check("post_reset_base_ticks", bt_cnt, 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
